// File: rtl/ysyx_rst_pkg.sv
// Shared definitions for the ysyx reset sequencer: FSM states, default
// parameter values and counter widths.
package ysyx_rst_pkg;

  typedef enum logic [2:0] {
    ST_SYNC      = 3'd0,
    ST_HOLD      = 3'd1,
    ST_RUN       = 3'd2,
    ST_HALTED    = 3'd3,
    ST_TIMED_OUT = 3'd4
  } state_e;

  localparam int unsigned DEF_SYNC_STAGES    = 2;
  localparam int unsigned DEF_HOLD_CYCLES    = 50;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1650000;

  localparam int unsigned CYCLE_W = 32;
  localparam int unsigned HOLD_W  = 16;

endpackage

// File: rtl/ysyx_reset_sync.sv
// Reset-deassertion synchronizer: asserts asynchronously with the raw reset,
// releases only after STAGES rising clock edges.
module ysyx_reset_sync #(
  parameter int unsigned STAGES = 1
) (
  input  logic clock,
  input  logic reset,
  output logic rst_n_sync
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(1);
    end
  end

  assign rst_n_sync = sync_q[STAGES-1];

endmodule

// File: rtl/ysyx_reset_sequencer.sv
// Core reset sequencer: synchronizes board reset release, holds the core in
// reset for a fixed time, then supervises the run for halt or timeout.
module ysyx_reset_sequencer
  import ysyx_rst_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               halt_req,
  input  logic               soft_reset_req,
  output logic               core_reset,
  output logic               running,
  output logic               halted,
  output logic               timed_out,
  output logic [CYCLE_W-1:0] cycle_count
);

  localparam logic [HOLD_W-1:0]  HoldLast    = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CYCLE_W-1:0] TimeoutLast = CYCLE_W'(TIMEOUT_CYCLES - 1);
  localparam bit                 TimeoutEn   = (TIMEOUT_CYCLES != 0);

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [CYCLE_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic               rst_n_sync;

  // The state register samples the synchronizer output, so it completes the
  // chain: HOLD is entered on the SYNC_STAGES-th edge after release, while its
  // D input still reads SYNC whenever the raw release lands.
  ysyx_reset_sync #(
    .STAGES(SYNC_STAGES - 1)
  ) u_sync (
    .clock     (clock),
    .reset     (reset),
    .rst_n_sync(rst_n_sync)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_SYNC;
      hold_cnt_q  <= '0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    unique case (state_q)
      ST_SYNC: begin
        if (rst_n_sync) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end
      end
      ST_HOLD: begin
        if (soft_reset_req) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HoldLast) begin
          state_d     = ST_RUN;
          hold_cnt_d  = '0;
          cycle_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      // Soft reset beats halt, and halt beats timeout.
      ST_RUN: begin
        if (soft_reset_req) begin
          state_d     = ST_HOLD;
          hold_cnt_d  = '0;
          cycle_cnt_d = '0;
        end else if (halt_req) begin
          state_d = ST_HALTED;
        end else if (TimeoutEn && (cycle_cnt_q == TimeoutLast)) begin
          state_d = ST_TIMED_OUT;
        end else if (cycle_cnt_q != '1) begin
          cycle_cnt_d = cycle_cnt_q + 1'b1;
        end
      end
      ST_HALTED, ST_TIMED_OUT: begin
        if (soft_reset_req) begin
          state_d     = ST_HOLD;
          hold_cnt_d  = '0;
          cycle_cnt_d = '0;
        end
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase
  end

  assign core_reset  = (state_q != ST_RUN);
  assign running     = (state_q == ST_RUN);
  assign halted      = (state_q == ST_HALTED);
  assign timed_out   = (state_q == ST_TIMED_OUT);
  assign cycle_count = cycle_cnt_q;

endmodule

// File: tb/tb_ysyx_reset_sequencer.sv
// Self-checking bench for ysyx_reset_sequencer: directed vector table, hand
// sequences for async reset and saturation, and randomized model comparison.
module tb_ysyx_reset_sequencer;

  localparam int SYNC = 2;
  localparam int HOLD = 4;
  localparam int TO   = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        halt_req = 1'b0;
  logic        soft_reset_req = 1'b0;
  logic        core_reset, running, halted, timed_out;
  logic [31:0] cycle_count;

  logic        reset2 = 1'b0;
  logic        halt2 = 1'b0;
  logic        soft2 = 1'b0;
  logic        core_reset2, running2, halted2, timed_out2;
  logic [31:0] cycle_count2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          r;
    bit          h;
    bit          s;
    logic [35:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #5 clock = ~clock;

  ysyx_reset_sequencer #(
    .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset), .halt_req(halt_req),
    .soft_reset_req(soft_reset_req), .core_reset(core_reset),
    .running(running), .halted(halted), .timed_out(timed_out),
    .cycle_count(cycle_count)
  );

  ysyx_reset_sequencer #(
    .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(0)
  ) dutSat (
    .clock(clock), .reset(reset2), .halt_req(halt2),
    .soft_reset_req(soft2), .core_reset(core_reset2),
    .running(running2), .halted(halted2), .timed_out(timed_out2),
    .cycle_count(cycle_count2)
  );

  // Reference model: counts remaining sync and hold edges, then tracks the
  // run counter and the two sticky end-of-run flags.
  int          syncLeft = SYNC;
  int          holdLeft = 0;
  logic [31:0] runCount = '0;
  bit          haltedM = 1'b0;
  bit          timedM = 1'b0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      syncLeft = SYNC;
      holdLeft = 0;
      runCount = '0;
      haltedM  = 1'b0;
      timedM   = 1'b0;
    end else if (syncLeft > 0) begin
      syncLeft = syncLeft - 1;
      if (syncLeft == 0) holdLeft = HOLD;
    end else if (holdLeft > 0) begin
      if (soft_reset_req) holdLeft = HOLD;
      else holdLeft = holdLeft - 1;
    end else if (haltedM || timedM) begin
      if (soft_reset_req) begin
        haltedM  = 1'b0;
        timedM   = 1'b0;
        holdLeft = HOLD;
        runCount = '0;
      end
    end else if (soft_reset_req) begin
      holdLeft = HOLD;
      runCount = '0;
    end else if (halt_req) begin
      haltedM = 1'b1;
    end else if (runCount == 32'(TO - 1)) begin
      timedM = 1'b1;
    end else if (runCount != 32'hFFFF_FFFF) begin
      runCount = runCount + 1;
    end
  end

  function automatic logic [35:0] modelOut();
    bit active;
    active = (syncLeft == 0) && (holdLeft == 0) && !haltedM && !timedM;
    return {!active, active, haltedM, timedM, runCount};
  endfunction

  function automatic logic [35:0] pack(bit cr, bit run, bit hl, bit to, logic [31:0] cnt);
    return {cr, run, hl, to, cnt};
  endfunction

  function automatic void addVec(bit r, bit h, bit s, bit cr, bit run, bit hl, bit to,
                                 logic [31:0] cnt);
    vec_t v;
    v.r = r;
    v.h = h;
    v.s = s;
    v.exp = pack(cr, run, hl, to, cnt);
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input bit r, input bit h, input bit s);
    @(negedge clock);
    reset = r;
    halt_req = h;
    soft_reset_req = s;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got cr=%b run=%b halt=%b to=%b cnt=%h, want cr=%b run=%b halt=%b to=%b cnt=%h",
               name, act[35], act[34], act[33], act[32], act[31:0],
               exp[35], exp[34], exp[33], exp[32], exp[31:0]);
    end
  endtask

  function automatic logic [35:0] dutOut();
    return {core_reset, running, halted, timed_out, cycle_count};
  endfunction

  function automatic logic [35:0] satOut();
    return {core_reset2, running2, halted2, timed_out2, cycle_count2};
  endfunction

  initial begin
    // Release, hold, run 5 cycles, halt; soft-reset paths; timeout; halt-vs-timeout.
    addVec(1, 0, 1, 1, 0, 0, 0, 0);
    addVec(1, 1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) addVec(1, 0, 0, 1, 0, 0, 0, 0);
    addVec(1, 0, 0, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 5; k++) addVec(1, 0, 0, 0, 1, 0, 0, 32'(k));
    addVec(1, 1, 0, 1, 0, 1, 0, 5);
    addVec(1, 1, 0, 1, 0, 1, 0, 5);
    addVec(1, 0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) addVec(1, 0, 0, 1, 0, 0, 0, 0);
    addVec(1, 0, 0, 0, 1, 0, 0, 0);
    addVec(1, 1, 1, 1, 0, 0, 0, 0);
    addVec(1, 0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) addVec(1, 0, 0, 1, 0, 0, 0, 0);
    addVec(1, 0, 0, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 9; k++) addVec(1, 0, 0, 0, 1, 0, 0, 32'(k));
    addVec(1, 0, 0, 1, 0, 0, 1, 9);
    addVec(1, 1, 0, 1, 0, 0, 1, 9);
    addVec(1, 0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) addVec(1, 0, 0, 1, 0, 0, 0, 0);
    addVec(1, 0, 0, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 9; k++) addVec(1, 0, 0, 0, 1, 0, 0, 32'(k));
    addVec(1, 1, 0, 1, 0, 1, 0, 9);
    addVec(1, 0, 1, 1, 0, 0, 0, 0);

    @(posedge clock);
    #1;
    checkOutput("reset_state", dutOut(), pack(1, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].r, vecs[i].h, vecs[i].s);
      checkOutput($sformatf("vec%0d", i), dutOut(), vecs[i].exp);
    end

    // Back into RUN, then drop reset between edges.
    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0);
    checkOutput("pre_reset_run", dutOut(), pack(0, 1, 0, 0, 2));
    #3;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_run", dutOut(), pack(1, 0, 0, 0, 0));
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1, 0, 0);
      checkOutput($sformatf("rerelease_edge%0d", i), dutOut(),
                  (i < 6) ? pack(1, 0, 0, 0, 0) : pack(0, 1, 0, 0, 0));
    end

    // Drop reset while in HOLD.
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_hold", dutOut(), pack(1, 0, 0, 0, 0));

    // Randomized run against the reference model.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      checkOutput("random", dutOut(), modelOut());
      reset = ($urandom_range(0, 149) != 0);
      halt_req = ($urandom_range(0, 19) == 0);
      soft_reset_req = ($urandom_range(0, 29) == 0);
      if (!reset) begin
        #1;
        checkOutput("random_async", dutOut(), modelOut());
      end
    end

    // Saturation with the timeout disabled.
    @(negedge clock);
    reset2 = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    checkOutput("sat_running", satOut(), pack(0, 1, 0, 0, 4));
    @(negedge clock);
    force dutSat.cycle_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dutSat.cycle_cnt_q;
    @(posedge clock);
    #1;
    checkOutput("sat_fffe", satOut(), pack(0, 1, 0, 0, 32'hFFFF_FFFE));
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      checkOutput($sformatf("sat_hold%0d", i), satOut(), pack(0, 1, 0, 0, 32'hFFFF_FFFF));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_reset_sequencer.md
YSYX_RESET_SEQUENCER -- requirements
Module: ysyx_reset_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of flops in the reset-deassertion synchronizer (legal range 2..4).
REQ-002 SHALL have parameter HOLD_CYCLES, default 50, meaning the number of cycles core_reset stays asserted after the synchronized release (legal range 1..65535).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1650000, meaning the maximum number of RUN cycles allowed; 0 disables the timeout.
REQ-004 SHALL have port clock, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low board/testbench reset.
REQ-006 SHALL have port halt_req, input, 1 bit: core end-of-program indication, sampled in RUN.
REQ-007 SHALL have port soft_reset_req, input, 1 bit: single-cycle request to restart the core.
REQ-008 SHALL have port core_reset, output, 1 bit: active-high synchronous reset driven to ysyxNonSoCFull.
REQ-009 SHALL have port running, output, 1 bit: high only in RUN.
REQ-010 SHALL have port halted, output, 1 bit: high only in HALTED.
REQ-011 SHALL have port timed_out, output, 1 bit: high only in TIMED_OUT.
REQ-012 SHALL have port cycle_count, output, 32 bits: number of completed RUN cycles.

Function
REQ-013 SHALL implement the states SYNC, HOLD, RUN, HALTED and TIMED_OUT; all outputs SHALL be registered or decoded from state only.
REQ-014 SYNC: core_reset=1. SHALL move to HOLD on the edge where the synchronizer output first reads 1, which is the SYNC_STAGES-th rising edge after reset rises.
REQ-015 HOLD: core_reset=1 and hold_cnt increments each cycle. SHALL move to RUN on the edge where hold_cnt==HOLD_CYCLES-1, so core_reset is sampled high by the core for exactly HOLD_CYCLES cycles.
REQ-016 RUN: core_reset=0, running=1. cycle_count SHALL read 0 in the first RUN cycle, increment by 1 per cycle, and saturate at 32'hFFFF_FFFF without wrapping.
REQ-017 RUN with halt_req=1 SHALL move to HALTED on the next edge; cycle_count SHALL freeze at its value in that cycle.
REQ-018 RUN with TIMEOUT_CYCLES!=0, cycle_count==TIMEOUT_CYCLES-1 and halt_req=0 SHALL move to TIMED_OUT on the next edge.
REQ-019 When halt and timeout conditions occur in the same cycle, halt SHALL win.
REQ-020 HALTED and TIMED_OUT: core_reset=1 (core frozen). The state SHALL be held until soft_reset_req or reset.
REQ-021 soft_reset_req=1 in RUN, HALTED or TIMED_OUT SHALL move to HOLD on the next edge and clear hold_cnt, cycle_count and all flags; in RUN it SHALL take priority over halt and timeout.
REQ-022 soft_reset_req=1 in HOLD SHALL restart hold_cnt from 0; in SYNC it SHALL be ignored.
REQ-023 halt_req SHALL be ignored outside RUN.

Reset
REQ-024 reset=0 SHALL asynchronously force state=SYNC, core_reset=1, running=halted=timed_out=0, cycle_count=0, hold_cnt=0 and all synchronizer flops=0, from any state including mid-HOLD and mid-RUN.
REQ-025 Release of reset SHALL only take effect through the synchronizer; no flop other than the first synchronizer stage SHALL see an unsynchronized release.

Structure
REQ-026 The state enum, the default parameter values and the cycle_count width SHALL live in package ysyx_rst_pkg.
REQ-027 The synchronizer SHALL be the sub-module ysyx_reset_sync (parameter STAGES; ports clock, reset, rst_n_sync), instantiated once.

Verification (SYNC_STAGES=2, HOLD_CYCLES=4, TIMEOUT_CYCLES=10 unless noted)
REQ-028 Release reset at a falling edge -> core_reset falls at the 6th rising edge after release; running=1 from that edge.
REQ-029 Run 5 cycles, then assert halt_req for 1 cycle -> halted=1 on the next edge, cycle_count frozen at 5, core_reset=1.
REQ-030 Never assert halt_req -> timed_out=1 exactly 10 edges after RUN entry, cycle_count=9, core_reset=1.
REQ-031 Assert halt_req in the cycle where cycle_count=9 -> halted=1 and timed_out=0.
REQ-032 soft_reset_req in TIMED_OUT -> HOLD for 4 cycles, then RUN with cycle_count=0; soft_reset_req together with halt_req in RUN -> HOLD.
REQ-033 Pull reset low mid-RUN between clock edges -> core_reset=1 and cycle_count=0 immediately; after release the REQ-028 timing repeats. With TIMEOUT_CYCLES=0, forcing cycle_count near saturation -> it holds at FFFF_FFFF.
